multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I core subset (lw, sw, R-type, I-type ALU, beq, jal). It sequences a shared datapath: one memory, one ALU, and the PC/IR/OldPC/ALUOut/Data registers. Per state, it drives datapath selects and write enables, and decodes ALUControl from op/funct3/funct7b5. A memory-ready handshake stretches the fetch, load and store states.

Parameters:
MEM_WAIT_EN, 1, 1: mem_ready gates the memory states; 0: mem_ready ignored (treated as 1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
op  in  7  opcode, Instr[6:0] from IR.
funct3  in  3  Instr[14:12].
funct7b5  in  1  Instr[30].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory has completed the current access this cycle.
PCWrite  out  1  PC load enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
MemWrite  out  1  memory write enable.
IRWrite  out  1  IR and OldPC load enable.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
ALUControl  out  3  ALU function: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
RegWrite  out  1  register file write enable.
illegal_instr  out  1  one-cycle pulse in Decode for an unsupported opcode.
state  out  4  current state, for debug.

Behaviour:
- Reset: asynchronous and active-low. While reset_n = 0:
  - state = FETCH (0);
  - PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are forced to 0.
  - Select outputs take their FETCH values.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10
  - Codes 11-15 are unreachable; if reached, next state is FETCH and all enables are 0.
- Moore outputs per state; any output not listed is 0/00. ALUOp is internal: 00 = add, 01 = sub, 10 = funct.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
    - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
    - Any other op: illegal_instr=1, next state FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: op=0000011 -> MEMREAD, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until the cycle where mem_ready=1, then go to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next: ALUWB (writes rd = OldPC+4).
- ImmSrc: combinational from op in every state.
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; everything else -> 00.
- ALUControl: combinational.
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, decoded by funct3:
    - 000: if op[5]&funct7b5 then 001, else 000;
    - 010 -> 101; 110 -> 011; 111 -> 010;
    - any other funct3 -> 000.
- Instruction latency with mem_ready tied high:
  - lw: 5 cycles; sw, R-type, I-type, jal: 4 cycles; beq: 3 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: state returns to FETCH immediately. No partial write enable may glitch high after reset_n falls.

Test Plan:
- Reset: reset_n=0 mid-EXECR -> state=0, and PCWrite, IRWrite, MemWrite, RegWrite all 0 on the same cycle. After release with mem_ready=1: IRWrite=1, PCWrite=1.
- lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4 then 0; RegWrite=1 only in state 4 with ResultSrc=01; ImmSrc=00.
- sw with mem_ready low for 2 cycles in MEMWRITE -> state sequence 0,1,2,5,5,5 then 0. MemWrite=1 for all three state-5 cycles; ImmSrc=01.
- R-type, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. With funct7b5=0 -> 000. With funct3=010 -> 101.
- beq, zero=1 -> PCWrite=1 in BEQ and ALUControl=001. With zero=0 -> PCWrite=0. Both cases return to FETCH.
- jal -> state sequence 0,1,10,8; PCWrite=1 in state 10; ImmSrc=11. Unsupported op=1110011 -> illegal_instr=1 for one cycle in DECODE, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
// Moore-style state outputs plus combinational ImmSrc / ALUControl decode.
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic       mem_ok;
  logic [1:0] alu_op;
  logic       pc_write_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       illegal_c;

  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ok;
        pc_write_c = mem_ok;
        state_d    = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_SUB;
        pc_write_c = zero;
      end
      S_JAL: begin
        // Link value OldPC+4 is formed here and written back in ALUWB.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Gate enables with reset so nothing writes while reset_n is low.
  assign PCWrite       = pc_write_c & reset_n;
  assign MemWrite      = mem_write_c & reset_n;
  assign IRWrite       = ir_write_c & reset_n;
  assign RegWrite      = reg_write_c & reset_n;
  assign illegal_instr = illegal_c & reset_n;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model pushes per-cycle
// expectations, a monitor compares them against the DUT on each falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       rw;
    logic       ill;
  } out_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  out_t  expq[$];
  string nameq[$];
  out_t  act;
  int    vectors = 0;
  int    miscompares = 0;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite, illegal_instr};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic supported(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Arithmetic function requested by an R/I instruction; only R-type can subtract.
  function automatic logic [2:0] arith(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic out_t expect_out(input int st, input logic mr, input logic z, input logic rst);
    out_t o;
    o     = '0;
    o.st  = rst ? 4'd0 : 4'(st);
    o.imm = imm_of(cur_op);
    if (rst) begin
      o.sb = 2'b10;
      o.rs = 2'b10;
      return o;
    end
    case (st)
      0:  begin o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr; end
      1:  begin o.sa = 2'b01; o.sb = 2'b01; o.ill = !supported(cur_op); end
      2:  begin o.sa = 2'b10; o.sb = 2'b01; end
      3:  o.adr = 1'b1;
      4:  begin o.rs = 2'b01; o.rw = 1'b1; end
      5:  begin o.adr = 1'b1; o.mw = 1'b1; end
      6:  begin o.sa = 2'b10; o.alu = arith(cur_op, cur_f3, cur_f7); end
      7:  begin o.sa = 2'b10; o.sb = 2'b01; o.alu = arith(cur_op, cur_f3, cur_f7); end
      8:  o.rw = 1'b1;
      9:  begin o.sa = 2'b10; o.alu = 3'b001; o.pcw = z; end
      10: begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input int st, input logic mr, input logic z, input logic rst, input string nm);
    @(posedge clk);
    #1;
    op        = cur_op;
    funct3    = cur_f3;
    funct7b5  = cur_f7;
    mem_ready = mr;
    zero      = z;
    reset_n   = !rst;
    expq.push_back(expect_out(st, mr, z, rst));
    nameq.push_back(nm);
  endtask

  task automatic mem_phase(input int st, input int stalls, input string nm);
    for (int i = 0; i < stalls; i++) step(st, 1'b0, rb(), 1'b0, nm);
    step(st, 1'b1, rb(), 1'b0, nm);
  endtask

  task automatic set_instr(input int kind, input logic [2:0] f3, input logic f7);
    logic [6:0] ill_ops [5];
    ill_ops = '{7'b1110011, 7'b0010111, 7'b0110111, 7'b1100111, 7'b0000000};
    case (kind)
      K_LW:    cur_op = 7'b0000011;
      K_SW:    cur_op = 7'b0100011;
      K_R:     cur_op = 7'b0110011;
      K_I:     cur_op = 7'b0010011;
      K_BEQ:   cur_op = 7'b1100011;
      K_JAL:   cur_op = 7'b1101111;
      default: cur_op = ill_ops[$urandom_range(0, 4)];
    endcase
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  task automatic run(input int kind, input int fs, input int ms, input logic z,
                     input logic [2:0] f3, input logic f7, input string nm);
    set_instr(kind, f3, f7);
    mem_phase(0, fs, nm);
    step(1, rb(), rb(), 1'b0, nm);
    case (kind)
      K_LW:  begin step(2, rb(), rb(), 1'b0, nm); mem_phase(3, ms, nm); step(4, rb(), rb(), 1'b0, nm); end
      K_SW:  begin step(2, rb(), rb(), 1'b0, nm); mem_phase(5, ms, nm); end
      K_R:   begin step(6, rb(), rb(), 1'b0, nm); step(8, rb(), rb(), 1'b0, nm); end
      K_I:   begin step(7, rb(), rb(), 1'b0, nm); step(8, rb(), rb(), 1'b0, nm); end
      K_BEQ: step(9, rb(), z, 1'b0, nm);
      K_JAL: begin step(10, rb(), rb(), 1'b0, nm); step(8, rb(), rb(), 1'b0, nm); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      out_t  e;
      string nm;
      e  = expq.pop_front();
      nm = nameq.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got st=%0d outs=%h, expected st=%0d outs=%h", nm, act.st, act, e.st, e);
      end else begin
        $display("ok   %s: st=%0d outs=%h", nm, e.st, e);
      end
    end
  end

  initial begin
    set_instr(K_R, 3'b000, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1, "reset");
    step(0, 1'b1, 1'b0, 1'b1, "reset");
    run(K_LW,  0, 0, 1'b0, 3'b010, 1'b0, "lw");
    run(K_SW,  0, 2, 1'b0, 3'b010, 1'b0, "sw_stall2");
    run(K_R,   0, 0, 1'b0, 3'b000, 1'b1, "r_sub");
    run(K_R,   0, 0, 1'b0, 3'b000, 1'b0, "r_add");
    run(K_R,   0, 0, 1'b0, 3'b010, 1'b0, "r_slt");
    run(K_I,   0, 0, 1'b0, 3'b000, 1'b1, "i_addi_f7");
    run(K_BEQ, 0, 0, 1'b1, 3'b000, 1'b0, "beq_taken");
    run(K_BEQ, 0, 0, 1'b0, 3'b000, 1'b0, "beq_not");
    run(K_JAL, 0, 0, 1'b0, 3'b000, 1'b0, "jal");
    set_instr(K_ILL, 3'b000, 1'b0);
    cur_op = 7'b1110011;
    mem_phase(0, 1, "illegal");
    step(1, 1'b1, 1'b0, 1'b0, "illegal");
    // Reset lands while the FSM sits in EXECR.
    set_instr(K_R, 3'b111, 1'b0);
    mem_phase(0, 0, "rst_mid");
    step(1, 1'b1, 1'b0, 1'b0, "rst_mid");
    step(0, 1'b1, 1'b0, 1'b1, "rst_mid_execr");
    step(0, 1'b1, 1'b0, 1'b1, "rst_hold");
    run(K_LW, 1, 1, 1'b0, 3'b010, 1'b0, "after_rst_lw");
    for (int n = 0; n < 60; n++) begin
      run($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3), rb(),
          3'($urandom_range(0, 7)), rb(), $sformatf("rand%0d", n));
    end
    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
